exec_controller: RTL
====================

# exec_controller

Run/stop/single-step sequencer for the simple CPU datapath. It debounces the front-panel EXEC and STEP buttons and runs a four-state FSM. It drives a clock-enable (CE) to every datapath register instead of gating the clock, and supports burst stepping, a PC breakpoint and halt-on-HALT-instruction. The datapath runs from CLOCK directly and advances only in cycles where CE=1.

## Interface

- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a button level is accepted.
- PC_WIDTH, 8: width of PC and BP_ADDR.
- STEP_WIDTH, 8: width of BURST_N and the internal step counter.

- CLOCK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EXEC  in  1  raw run/stop button, asynchronous, may bounce.
- STEP  in  1  raw single-step button, asynchronous, may bounce.
- BURST_N  in  STEP_WIDTH  CE cycles per STEP press; 0 is treated as 1.
- BP_EN  in  1  breakpoint enable.
- BP_ADDR  in  PC_WIDTH  breakpoint address.
- PC  in  PC_WIDTH  current datapath PC.
- HALT  in  1  datapath decoded a HALT instruction this cycle.
- CE  out  1  datapath clock enable.
- RES_SIG  out  1  datapath reset.
- RUNNING  out  1  high in RUN.
- STATE  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
- BP_HIT  out  1  sticky breakpoint-stop flag.

## Operation

- **Button path.** Each button goes through a 2-flop synchronizer, then a stability counter. The debounced level updates once the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the counter. A rising edge of the debounced level gives a one-cycle pulse, exec_p or step_p. Falling edges produce nothing.
- **RES_SIG.** Asserts asynchronously with RESET. Deasserts synchronously on the 2nd rising CLOCK edge after RESET falls.
- **bp_match.** BP_EN && PC==BP_ADDR && !first_run. first_run is a flag set on every transition into RUN and cleared after one RUN cycle. This lets execution resume from a breakpoint address.
- **FSM**, priority in the order listed:
  - IDLE: exec_p -> RUN. Else step_p -> STEP, loading cnt = (BURST_N==0 ? 1 : BURST_N). exec_p wins when both pulse together.
  - RUN: HALT -> HALTED. Else bp_match -> IDLE and set BP_HIT. Else exec_p -> IDLE. step_p is ignored.
  - STEP: HALT -> HALTED. Else exec_p -> IDLE (abort). Else if cnt==1 -> IDLE. Otherwise cnt decrements. Breakpoints and step_p are ignored.
  - HALTED: exits only via RESET. Button pulses are ignored.
- **CE** = (RUN && !HALT && !bp_match) || (STEP && !HALT). This is combinational from the registered state, PC, HALT and BP inputs. The HALT instruction and the instruction at the breakpoint address do not execute.
- **BP_HIT** is set on a breakpoint stop and cleared on the next accepted exec_p or step_p.
- **RUNNING** = (STATE==RUN).

## Timing

- Reset values: STATE=IDLE, CE=0, RUNNING=0, BP_HIT=0, RES_SIG=1, cnt=0, debounced levels=0, synchronizers=0, first_run=0.
- Button latency: a clean raw rising edge gives its pulse at cycle 2+DEBOUNCE_CYCLES+1 after the first synchronizing edge. The state changes on the next edge, and CE reflects the new state in that same cycle.
- A STEP press with BURST_N=N gives exactly N consecutive CE=1 cycles, then IDLE. N=255 gives 255 cycles.
- Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- A RESET assertion mid-RUN or mid-STEP drops CE and returns the FSM to IDLE immediately (asynchronous); cnt is cleared.
- HALT and bp_match together: HALTED wins, and BP_HIT stays unchanged.
- BURST_N is sampled only when leaving IDLE; later changes do not affect a burst in progress.

## Test plan

- DEBOUNCE_CYCLES=4; EXEC bounces 0/1 every 2 cycles for 20 cycles, then holds 1 -> exactly one exec_p and STATE 00->01. A 3-cycle EXEC pulse produces no transition.
- IDLE, BURST_N=3, STEP press -> CE high for exactly 3 cycles, STATE 10 then 00. Repeat with BURST_N=0 -> exactly 1 CE cycle.
- RUN with BP_EN=1, BP_ADDR=0x10, PC counting from 0x0C -> CE=0 in the cycle PC=0x10, STATE=00, BP_HIT=1. Next EXEC press -> BP_HIT=0 and CE=1 with PC=0x10; execution continues past it.
- RUN, assert HALT at PC=0x05 -> CE=0 that cycle, STATE=11. EXEC and STEP presses leave STATE=11; RESET returns STATE to 00.
- Mid-burst (BURST_N=10, after 4 CE cycles) press EXEC -> abort to IDLE after 4+k cycles with no RUN entry. Pulse EXEC and STEP in the same cycle in IDLE -> STATE=01.
- Assert RESET for 3 cycles during RUN -> CE=0, STATE=00 and RES_SIG=1 immediately. RES_SIG falls on the 2nd edge after RESET deasserts.

Source files
------------

// File: rtl/exec_controller.sv
`default_nettype none
// ============================================================================
// Module   : exec_controller
// Purpose  : Run/stop/single-step sequencer for the simple CPU datapath.
//            Debounces the EXEC and STEP buttons, sequences a four-state
//            FSM (IDLE/RUN/STEP/HALTED) and drives a datapath clock enable
//            with burst stepping, a PC breakpoint and halt-on-HALT.
// Revision : 1.0 - initial release
// ============================================================================
module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_WIDTH        = 8,
  parameter int STEP_WIDTH      = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  exec_i,
  input  logic                  step_i,
  input  logic [STEP_WIDTH-1:0] burst_n_i,
  input  logic                  bp_en_i,
  input  logic [PC_WIDTH-1:0]   bp_addr_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic                  halt_i,
  output logic                  ce_o,
  output logic                  res_sig_o,
  output logic                  running_o,
  output logic [1:0]            state_o,
  output logic                  bp_hit_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = EXEC, bit 1 = STEP
  // --------------------------------------------------------------------------
  logic [1:0] raw_btn;
  logic [1:0] pulse_btn;
  logic       exec_p;
  logic       step_p;

  assign raw_btn = {step_i, exec_i};
  assign exec_p  = pulse_btn[0];
  assign step_p  = pulse_btn[1];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] stable_cnt_q;

    // Synchronize the raw button, then accept a new level only after it has
    // disagreed with the accepted level for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        stable_cnt_q <= '0;
      end else begin
        sync1_q      <= raw_btn[gi];
        sync2_q      <= sync1_q;
        level_prev_q <= level_q;
        if (sync2_q != level_q) begin
          if (stable_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q      <= sync2_q;
            stable_cnt_q <= '0;
          end else begin
            stable_cnt_q <= stable_cnt_q + CNT_W'(1);
          end
        end else begin
          stable_cnt_q <= '0;
        end
      end
    end

    // Only rising edges of the accepted level are of interest.
    assign pulse_btn[gi] = level_q & ~level_prev_q;
  end

  // --------------------------------------------------------------------------
  // Datapath reset: asserted with RESET, released on the 2nd clock edge after
  // RESET falls so every datapath register sees a clean synchronous release.
  // --------------------------------------------------------------------------
  logic [1:0] res_sync_q;

  // Two-stage release shifter for the datapath reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      res_sync_q <= 2'b11;
    end else begin
      res_sync_q <= {res_sync_q[0], 1'b0};
    end
  end

  assign res_sig_o = res_sync_q[1];

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [STEP_WIDTH-1:0] cnt_q,       cnt_d;
  logic                  bp_hit_q,    bp_hit_d;
  logic                  first_run_q, first_run_d;
  logic                  bp_match;
  logic                  ce;

  // first_run masks the breakpoint for one cycle so RUN can resume from the
  // very address it stopped at.
  assign bp_match = bp_en_i && (pc_i == bp_addr_i) && !first_run_q;

  // State, burst counter and flag registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bp_hit_q    <= 1'b0;
      first_run_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bp_hit_q    <= bp_hit_d;
      first_run_q <= first_run_d;
    end
  end

  // Next-state, burst counter and clock-enable decode; HALT outranks all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bp_hit_d = bp_hit_q;
    ce       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (exec_p) begin
          state_d  = S_RUN;
          bp_hit_d = 1'b0;
        end else if (step_p) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
          cnt_d    = (burst_n_i == '0) ? STEP_WIDTH'(1) : burst_n_i;
        end
      end

      S_RUN: begin
        ce = !halt_i && !bp_match;
        if (halt_i) begin
          state_d = S_HALTED;
        end else if (bp_match) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end else if (exec_p) begin
          state_d = S_IDLE;
        end
      end

      S_STEP: begin
        ce = !halt_i;
        if (halt_i) begin
          state_d = S_HALTED;
        end else if (exec_p) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STEP_WIDTH'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STEP_WIDTH'(1);
        end
      end

      default: begin
        // HALTED: only RESET leaves this state.
        state_d = S_HALTED;
      end
    endcase

    first_run_d = (state_d == S_RUN) && (state_q != S_RUN);
  end

  assign ce_o      = ce;
  assign running_o = (state_q == S_RUN);
  assign state_o   = state_q;
  assign bp_hit_o  = bp_hit_q;

endmodule
`default_nettype wire
